alu_issue_arbiter: RTL and testbench



---
 rtl/alu_issue_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Shares one pipelined ALU between NR_REQ requesters. A round-robin
//   arbiter grants at most one request per cycle and drives the ALU bus
//   combinationally. Each issued op carries its requester id down a tag
//   pipeline. When the result returns ALU_LAT cycles later, it is captured
//   into an in-order response FIFO. A credit counter covers ops in the tag
//   pipeline plus ops in the FIFO, so the FIFO can never overflow.
// Ports
//   clk_i, rst_i           clock, async active-high reset
//   flush_i                kills all in-flight and buffered ops
//   req_valid_i/ready_o    per-requester handshake (ready is one-hot or zero)
//   req_op_i/a_i/b_i       packed per-requester operator and operands
//   alu_valid_o/op/a/b     issue bus to the ALU (zero when not valid)
//   alu_result_i/branch    ALU outputs, ALU_LAT cycles after issue
//   resp_*                 valid/ready response port (FIFO head)
module alu_issue_arbiter #(
  parameter int NR_REQ     = 3,
  parameter int XLEN       = 64,
  parameter int OP_W       = 7,
  parameter int ALU_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [NR_REQ-1:0]           req_valid_i,
  output logic [NR_REQ-1:0]           req_ready_o,
  input  logic [NR_REQ*OP_W-1:0]      req_op_i,
  input  logic [NR_REQ*XLEN-1:0]      req_a_i,
  input  logic [NR_REQ*XLEN-1:0]      req_b_i,
  output logic                        alu_valid_o,
  output logic [OP_W-1:0]             alu_op_o,
  output logic [XLEN-1:0]             alu_a_o,
  output logic [XLEN-1:0]             alu_b_o,
  input  logic [XLEN-1:0]             alu_result_i,
  input  logic                        alu_branch_res_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [$clog2(NR_REQ)-1:0]   resp_id_o,
  output logic [XLEN-1:0]             resp_result_o,
  output logic                        resp_branch_o
);

  localparam int ID_W  = $clog2(NR_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]       r_rr_ptr;
  logic [ALU_LAT-1:0]    r_tag_vld;
  logic [ID_W-1:0]       r_tag_id   [ALU_LAT];
  logic [ID_W-1:0]       r_fifo_id  [FIFO_DEPTH];
  logic [XLEN-1:0]       r_fifo_res [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_br;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic [31:0]           w_inflight;
  logic                  w_credit_ok;
  logic [31:0]           w_idx;
  logic                  w_hit;
  logic                  w_gnt_found;
  logic [ID_W-1:0]       w_gnt_id;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;

  // Credit check: ops still in the tag pipeline plus buffered responses.
  // Both terms come from registers, so a pop frees its credit one cycle later.
  always_comb begin
    w_inflight = 32'd0;
    for (int i = 0; i < ALU_LAT; i++) begin
      w_inflight = w_inflight + 32'(r_tag_vld[i]);
    end
    w_credit_ok = (w_inflight + 32'(r_count)) < 32'(FIFO_DEPTH);
  end

  // Round-robin search starting at r_rr_ptr, wrapping modulo NR_REQ.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = 32'd0;
    w_hit       = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      w_idx       = (32'(r_rr_ptr) + 32'(i)) % 32'(NR_REQ);
      w_hit       = !w_gnt_found && req_valid_i[w_idx[ID_W-1:0]];
      w_gnt_id    = w_hit ? w_idx[ID_W-1:0] : w_gnt_id;
      w_gnt_found = w_gnt_found | w_hit;
    end
    // Flush and reset both block issue for the current cycle.
    w_issue = w_gnt_found & w_credit_ok & ~flush_i & ~rst_i;
  end

  // Grant vector and ALU issue mux. The bus stays zero when nothing is issued.
  always_comb begin
    req_ready_o = '0;
    alu_valid_o = w_issue;
    alu_op_o    = '0;
    alu_a_o     = '0;
    alu_b_o     = '0;
    if (w_issue) begin
      req_ready_o[w_gnt_id] = 1'b1;
      alu_op_o = req_op_i[int'(w_gnt_id)*OP_W +: OP_W];
      alu_a_o  = req_a_i[int'(w_gnt_id)*XLEN +: XLEN];
      alu_b_o  = req_b_i[int'(w_gnt_id)*XLEN +: XLEN];
    end else begin
      req_ready_o = '0;
    end
  end

  // Round-robin pointer: after a grant, move just past the winner. Flush keeps it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= (w_gnt_id == ID_W'(NR_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  // Tag pipeline: one {valid,id} per ALU stage. The last stage lines up with alu_result_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_vld <= '0;
      for (int i = 0; i < ALU_LAT; i++) r_tag_id[i] <= '0;
    end else if (flush_i) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_issue;
      r_tag_id[0]  <= w_gnt_id;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign w_push = r_tag_vld[ALU_LAT-1] & ~flush_i;
  assign w_pop  = (r_count != '0) & resp_ready_i;
  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));

  // FIFO pointers and occupancy. Flush empties the FIFO and takes priority over push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage. It is cleared on reset so the head outputs read zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fifo_br <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_id[i]  <= '0;
        r_fifo_res[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_id[r_wptr]  <= r_tag_id[ALU_LAT-1];
      r_fifo_res[r_wptr] <= alu_result_i;
      r_fifo_br[r_wptr]  <= alu_branch_res_i;
    end
  end

  assign resp_valid_o  = (r_count != '0);
  assign resp_id_o     = r_fifo_id[r_rptr];
  assign resp_result_o = r_fifo_res[r_rptr];
  assign resp_branch_o = r_fifo_br[r_rptr];

  alu_issue_arbiter_chk #(
    .NR_REQ (NR_REQ)
  ) u_chk (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_full      (w_full),
    .i_req_valid (req_valid_i),
    .i_req_ready (req_ready_o)
  );

endmodule

// alu_issue_arbiter_chk
//   Property checker for the arbiter: no FIFO overflow, and grants are
//   one-hot and only given to requesters that are asking.
// Ports
//   i_clk, i_rst     clock and reset
//   i_push/pop/full  FIFO control
//   i_req_valid/rdy  request handshake vectors
module alu_issue_arbiter_chk #(
  parameter int NR_REQ = 3
) (
  input logic              i_clk,
  input logic              i_rst,
  input logic              i_push,
  input logic              i_pop,
  input logic              i_full,
  input logic [NR_REQ-1:0] i_req_valid,
  input logic [NR_REQ-1:0] i_req_ready
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && i_full && !i_pop));

  a_ready_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(i_req_ready));

  a_ready_needs_valid: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_req_ready & ~i_req_valid) == '0);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
  localparam int NR_REQ = 3;
  localparam int XLEN = 64;
  localparam int OP_W = 7;
  localparam int ALU_LAT = 2;
  localparam int FIFO_DEPTH = 4;
  localparam logic [OP_W-1:0] OP_ADD = 7'd0;
  localparam logic [OP_W-1:0] OP_SUB = 7'd1;
  localparam logic [OP_W-1:0] OP_XOR = 7'd2;
  localparam logic [OP_W-1:0] OP_BEQ = 7'd3;

  logic                   clk_i, rst_i, flush_i;
  logic [NR_REQ-1:0]      req_valid_i, req_ready_o;
  logic [NR_REQ*OP_W-1:0] req_op_i;
  logic [NR_REQ*XLEN-1:0] req_a_i, req_b_i;
  logic                   alu_valid_o;
  logic [OP_W-1:0]        alu_op_o;
  logic [XLEN-1:0]        alu_a_o, alu_b_o, alu_result_i;
  logic                   alu_branch_res_i;
  logic                   resp_valid_o, resp_ready_i, resp_branch_o;
  logic [1:0]             resp_id_o;
  logic [XLEN-1:0]        resp_result_o;

  typedef struct packed {
    logic [1:0]      id;
    logic [XLEN-1:0] res;
    logic            br;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass = 0;

  // Hand-computed results for operand set A: 10+5, 10-3, 6^3.
  logic [XLEN-1:0] res_a [3] = '{64'd15, 64'd7, 64'd5};

  alu_issue_arbiter #(
    .NR_REQ(NR_REQ), .XLEN(XLEN), .OP_W(OP_W), .ALU_LAT(ALU_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .alu_valid_o(alu_valid_o), .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_branch_res_i(alu_branch_res_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_result_o(resp_result_o), .resp_branch_o(resp_branch_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ALU model with two-cycle latency (part of the environment)
  logic [XLEN-1:0] alu_s1_res, alu_s2_res;
  logic            alu_s1_br, alu_s2_br;

  function automatic logic [XLEN-1:0] alu_f(input logic [OP_W-1:0] op,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_BEQ:  return a - b;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk_i) begin
    alu_s1_res <= alu_valid_o ? alu_f(alu_op_o, alu_a_o, alu_b_o) : 64'd0;
    alu_s1_br  <= alu_valid_o && (alu_op_o == OP_BEQ) && (alu_a_o == alu_b_o);
    alu_s2_res <= alu_s1_res;
    alu_s2_br  <= alu_s1_br;
  end
  assign alu_result_i     = alu_s2_res;
  assign alu_branch_res_i = alu_s2_br;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Scoreboard monitor: compares each accepted response with the queue head
  always @(negedge clk_i) begin
    if (!rst_i && resp_valid_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL resp_unexpected: got id %0d result %0h, expected no response (t=%0t)",
                 resp_id_o, resp_result_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_id", 64'(resp_id_o), 64'(mon_e.id));
        check("resp_result", resp_result_o, mon_e.res);
        check("resp_branch", 64'(resp_branch_o), 64'(mon_e.br));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic push_exp(input int id, input logic [XLEN-1:0] res, input logic br);
    exp_t t;
    t.id  = 2'(id);
    t.res = res;
    t.br  = br;
    exp_q.push_back(t);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s: got %0d responses outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_ops_a();
    req_op_i = {OP_XOR, OP_SUB, OP_ADD};
    req_a_i  = {64'd6, 64'd10, 64'd10};
    req_b_i  = {64'd3, 64'd3, 64'd5};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] oh;
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 3'b111; resp_ready_i = 1'b0;
    set_ops_a();
    step(); step();
    // Reset state: nothing granted or visible even with requests pending
    smp();
    check("rst_ready", 64'(req_ready_o), 64'd0);
    check("rst_alu_valid", 64'(alu_valid_o), 64'd0);
    check("rst_alu_a", alu_a_o, 64'd0);
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_resp_result", resp_result_o, 64'd0);
    step();
    rst_i = 1'b0; req_valid_i = 3'b000;
    step();

    // Test 1: single ADD from req0
    req_op_i[0 +: OP_W] = OP_ADD; req_a_i[0 +: XLEN] = 64'd1; req_b_i[0 +: XLEN] = 64'd2;
    req_valid_i = 3'b001; resp_ready_i = 1'b1;
    smp();
    check("t1_ready", 64'(req_ready_o), 64'd1);
    check("t1_alu_valid", 64'(alu_valid_o), 64'd1);
    check("t1_alu_op", 64'(alu_op_o), 64'(OP_ADD));
    check("t1_alu_a", alu_a_o, 64'd1);
    check("t1_alu_b", alu_b_o, 64'd2);
    push_exp(0, 64'd3, 1'b0);
    step(); req_valid_i = 3'b000;
    smp(); check("t1_resp_t1", 64'(resp_valid_o), 64'd0);
    step();
    smp(); check("t1_resp_t2", 64'(resp_valid_o), 64'd0);
    step();
    smp(); check("t1_resp_t3", 64'(resp_valid_o), 64'd1);
    step();
    drain("t1_drain");

    // Test 2: all valid, continuous; rr_ptr=1 after test 1
    set_ops_a();
    req_valid_i = 3'b111;
    for (int n = 0; n < 8; n++) begin
      smp();
      oh = 3'(1 << ((1 + n) % 3));
      check("t2_ready", 64'(req_ready_o), 64'(oh));
      check("t2_alu_valid", 64'(alu_valid_o), 64'd1);
      push_exp((1 + n) % 3, res_a[(1 + n) % 3], 1'b0);
      step();
    end
    req_valid_i = 3'b000;
    drain("t2_drain");

    // Test 3/4: fill with consumer stalled, then drain while requesting
    resp_ready_i = 1'b0; req_valid_i = 3'b111;
    for (int n = 0; n < 8; n++) begin
      smp();
      if (n < 4) begin
        oh = 3'(1 << (n % 3));
        push_exp(n % 3, res_a[n % 3], 1'b0);
      end else begin
        oh = 3'b000;
      end
      check("t3_fill_ready", 64'(req_ready_o), 64'(oh));
      step();
    end
    resp_ready_i = 1'b1;
    smp();
    check("t4_pop_cycle_ready", 64'(req_ready_o), 64'd0);
    step();
    for (int n = 0; n < 6; n++) begin
      smp();
      oh = 3'(1 << ((1 + n) % 3));
      check("t4_regrant", 64'(req_ready_o), 64'(oh));
      push_exp((1 + n) % 3, res_a[(1 + n) % 3], 1'b0);
      step();
    end
    req_valid_i = 3'b000;
    drain("t4_drain");

    // Test 5: flush with two in flight plus one buffered; rr_ptr=1
    resp_ready_i = 1'b0; req_valid_i = 3'b111;
    for (int n = 0; n < 3; n++) begin
      smp();
      oh = 3'(1 << ((1 + n) % 3));
      check("t5_pre_ready", 64'(req_ready_o), 64'(oh));
      step();
    end
    flush_i = 1'b1;
    smp();
    check("t5_flush_ready", 64'(req_ready_o), 64'd0);
    check("t5_flush_alu_valid", 64'(alu_valid_o), 64'd0);
    check("t5_flush_resp_valid", 64'(resp_valid_o), 64'd1);
    step();
    flush_i = 1'b0; req_valid_i = 3'b000; resp_ready_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      smp();
      check("t5_post_resp_valid", 64'(resp_valid_o), 64'd0);
      step();
    end
    resp_ready_i = 1'b0; req_valid_i = 3'b111;
    for (int n = 0; n < 5; n++) begin
      smp();
      if (n < 4) begin
        oh = 3'(1 << ((1 + n) % 3));
        push_exp((1 + n) % 3, res_a[(1 + n) % 3], 1'b0);
      end else begin
        oh = 3'b000;
      end
      check("t5_refill_ready", 64'(req_ready_o), 64'(oh));
      step();
    end
    req_valid_i = 3'b000; resp_ready_i = 1'b1;
    drain("t5_drain");

    // Test 6: asynchronous reset mid-stream; rr_ptr=2
    req_op_i[2*OP_W +: OP_W] = OP_BEQ; req_a_i[2*XLEN +: XLEN] = 64'd9; req_b_i[2*XLEN +: XLEN] = 64'd9;
    resp_ready_i = 1'b0; req_valid_i = 3'b111;
    step(); step(); step();
    #1;
    check("t6_pre_alu_valid", 64'(alu_valid_o), 64'd1);
    check("t6_pre_resp_valid", 64'(resp_valid_o), 64'd1);
    #1 rst_i = 1'b1;
    #1;
    check("t6_rst_ready", 64'(req_ready_o), 64'd0);
    check("t6_rst_alu_valid", 64'(alu_valid_o), 64'd0);
    check("t6_rst_alu_b", alu_b_o, 64'd0);
    check("t6_rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("t6_rst_resp_id", 64'(resp_id_o), 64'd0);
    exp_q.delete();
    step();
    rst_i = 1'b0; req_valid_i = 3'b100; resp_ready_i = 1'b1;
    smp();
    check("t6_first_ready", 64'(req_ready_o), 64'd4);
    check("t6_first_alu_a", alu_a_o, 64'd9);
    push_exp(2, 64'd0, 1'b1);
    step();
    req_valid_i = 3'b000;
    drain("t6_drain");
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
